// File: rtl/mdu_pkg.sv
// Shared MDU operation encodings and the mul/div classification helper.
// MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU to the multi-cycle op set.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    function automatic logic md_is_muldiv(input logic [3:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit multiply/divide result generator for ex_mdu.
// With MDU_MADD_EN the multiply-accumulate ops fold the product into the current HI/LO.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] sprod_s;
    logic [63:0] uprod_s;
    logic        sdiv_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] dvs_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] q_s;
    logic [31:0] r_s;

    assign sprod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod_s = {32'd0, a} * {32'd0, b};

    // Signed division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with zero remainder.
    assign div0    = (b == 32'd0);
    assign sdiv_s  = (op == MD_DIV);
    assign neg_a_s = sdiv_s & a[31];
    assign neg_b_s = sdiv_s & b[31];
    assign mag_a_s = neg_a_s ? (32'd0 - a) : a;
    assign mag_b_s = neg_b_s ? (32'd0 - b) : b;
    assign dvs_s   = div0 ? 32'd1 : mag_b_s;
    assign uq_s    = mag_a_s / dvs_s;
    assign ur_s    = mag_a_s % dvs_s;
    assign q_s     = (neg_a_s ^ neg_b_s) ? (32'd0 - uq_s) : uq_s;
    assign r_s     = neg_a_s ? (32'd0 - ur_s) : ur_s;

`ifdef MDU_MADD_EN
    logic        madd_sgn_s;
    logic        madd_sub_s;
    logic [63:0] madd_term_s;
    logic [63:0] madd_sum_s;

    assign madd_sgn_s  = (op == MD_MADD) || (op == MD_MSUB);
    assign madd_sub_s  = (op == MD_MSUB) || (op == MD_MSUBU);
    assign madd_term_s = madd_sgn_s ? sprod_s : uprod_s;
    assign madd_sum_s  = madd_sub_s ? ({hi, lo} - madd_term_s) : ({hi, lo} + madd_term_s);
`endif

    // Result select; anything that does not produce a result passes HI/LO through.
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MD_MULT:  {res_hi, res_lo} = sprod_s;
            MD_MULTU: {res_hi, res_lo} = uprod_s;
            MD_DIV, MD_DIVU: begin
                if (div0) begin
                    res_hi = hi;
                    res_lo = lo;
                end else begin
                    res_hi = r_s;
                    res_lo = q_s;
                end
            end
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: {res_hi, res_lo} = madd_sum_s;
`endif
            default: begin
                res_hi = hi;
                res_lo = lo;
            end
        endcase
    end

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit: latency counter, pending result and HI/LO registers.
// Build option MDU_MADD_EN enables the multiply-accumulate family.
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic             pend_wr_r;
    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;
    logic             div0_s;
    logic             idle_s;
    logic             start_mul_s;
    logic             start_div_s;
    logic             start_mthi_s;
    logic             start_mtlo_s;

    mdu_calc u_calc (
        .op     (md_op),
        .a      (rs_val),
        .b      (rt_val),
        .hi     (hi_r),
        .lo     (lo_r),
        .res_hi (res_hi_s),
        .res_lo (res_lo_s),
        .div0   (div0_s)
    );

    assign idle_s = (cnt_r == {CNT_W{1'b0}});
    assign busy   = (start & md_is_muldiv(md_op)) | ~idle_s;
    assign hi     = hi_r;
    assign lo     = lo_r;

    // Decode an accepted start; anything arriving while a result is pending is dropped.
    always_comb begin
        start_mul_s  = 1'b0;
        start_div_s  = 1'b0;
        start_mthi_s = 1'b0;
        start_mtlo_s = 1'b0;
        if (start && idle_s) begin
            case (md_op)
                MD_MULT, MD_MULTU: start_mul_s  = 1'b1;
                MD_DIV, MD_DIVU:   start_div_s  = 1'b1;
                MD_MTHI:           start_mthi_s = 1'b1;
                MD_MTLO:           start_mtlo_s = 1'b1;
`ifdef MDU_MADD_EN
                MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: start_mul_s = 1'b1;
`endif
                default: start_mul_s = 1'b0;
            endcase
        end else begin
            start_mul_s = 1'b0;
        end
    end

    // Counter, pending result and HI/LO update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
        end else if (!idle_s) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if ((cnt_r == CNT_W'(1)) && pend_wr_r) begin
                hi_r <= pend_hi_r;
                lo_r <= pend_lo_r;
            end
        end else if (start_mul_s || start_div_s) begin
            cnt_r     <= start_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            pend_hi_r <= res_hi_s;
            pend_lo_r <= res_lo_s;
            pend_wr_r <= !(start_div_s && div0_s);
        end else begin
            if (start_mthi_s) hi_r <= rs_val;
            if (start_mtlo_s) lo_r <= rs_val;
        end
    end

    // HI/LO read port for MFHI/MFLO.
    always_comb begin
        case (md_op)
            MD_MFHI: md_rdata = hi_r;
            MD_MFLO: md_rdata = lo_r;
            default: md_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: vector table for mul/div results and busy length,
// plus hand sequences for MTHI/MTLO/MFxx, divide by zero, ignored starts and reset.
module tb_ex_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    int errors = 0;
    int checks = 0;

    ex_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_rdata (md_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          nbusy;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op, then count busy cycles (start cycle included) until busy drops.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nb);
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        #1;
        nb = busy ? 1 : 0;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = MD_NONE;
        while (busy && nb < 200) begin
            nb++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int nb;
        int n;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        6,  32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        6,  32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{MD_MULTU, 32'h80000000, 32'd3,        6,  32'h00000001, 32'h80000000};
        vecs[3] = '{MD_MULT,  32'h80000000, 32'd3,        6,  32'hFFFFFFFE, 32'h80000000};
        vecs[4] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 6,  32'h00000000, 32'h00000001};
        vecs[5] = '{MD_DIVU,  32'd100,      32'd7,        11, 32'd2,        32'd14};
        vecs[6] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        11, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[7] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 11, 32'h00000000, 32'h80000000};
        vecs[8] = '{MD_DIVU,  32'hFFFFFFFF, 32'd16,       11, 32'h0000000F, 32'h0FFFFFFF};
        vecs[9] = '{MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 11, 32'hFFFFFFFE, 32'h00000002};

        reset = 1'b1; start = 1'b0; md_op = MD_NONE; rs_val = 32'd0; rt_val = 32'd0;
        @(posedge clk);
        #1;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, nb);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(vecs[i].nbusy));
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // MTHI then divide by zero: HI keeps the moved value, LO keeps the last quotient.
        run_op(MD_MTHI, 32'h00001234, 32'd0, nb);
        chk("mthi_busy_cycles", 32'(nb), 32'd0);
        chk("mthi_hi", hi, 32'h00001234);
        run_op(MD_DIV, 32'd5, 32'd0, nb);
        chk("div0_busy_cycles", 32'(nb), 32'd11);
        chk("div0_hi", hi, 32'h00001234);
        chk("div0_lo", lo, 32'h00000002);

        // MTLO then same-cycle MFLO/MFHI reads.
        run_op(MD_MTLO, 32'hA5A5A5A5, 32'd0, nb);
        chk("mtlo_busy_cycles", 32'(nb), 32'd0);
        @(negedge clk);
        start = 1'b1; md_op = MD_MFLO;
        #1;
        chk("mflo_rdata", md_rdata, 32'hA5A5A5A5);
        chk("mflo_busy", {31'd0, busy}, 32'd0);
        md_op = MD_MFHI;
        #1;
        chk("mfhi_rdata", md_rdata, 32'h00001234);
        md_op = MD_NONE;
        #1;
        chk("none_rdata", md_rdata, 32'd0);
        start = 1'b0;

        // Second MULT two cycles in, and an MTHI, must both be ignored.
        @(negedge clk);
        start = 1'b1; md_op = MD_MULT; rs_val = 32'd3; rt_val = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = MD_NONE;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b1; md_op = MD_MULT; rs_val = 32'd5; rt_val = 32'd6;
            end else if (n == 2) begin
                start = 1'b1; md_op = MD_MTHI; rs_val = 32'h0000FFFF;
            end else begin
                start = 1'b0; md_op = MD_NONE;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0; md_op = MD_NONE;
        chk("overlap_edges_to_idle", 32'(n), 32'd5);
        chk("overlap_hi", hi, 32'd0);
        chk("overlap_lo", lo, 32'd12);

        // Multiply-accumulate carry from LO into HI, or a no-op when the feature is absent.
        run_op(MD_MTHI, 32'd0, 32'd0, nb);
        run_op(MD_MTLO, 32'hFFFFFFFF, 32'd0, nb);
        run_op(MD_MADDU, 32'd1, 32'd1, nb);
`ifdef MDU_MADD_EN
        chk("maddu_busy_cycles", 32'(nb), 32'd6);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
`else
        chk("maddu_busy_cycles", 32'(nb), 32'd0);
        chk("maddu_hi", hi, 32'd0);
        chk("maddu_lo", lo, 32'hFFFFFFFF);
`endif

        // Reset in the middle of a multiply clears everything at once and drops the result.
        run_op(MD_MTHI, 32'h0000CAFE, 32'd0, nb);
        @(negedge clk);
        start = 1'b1; md_op = MD_MULT; rs_val = 32'd9; rt_val = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = MD_NONE;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("postreset_hi", hi, 32'd0);
        chk("postreset_lo", lo, 32'd0);
        chk("postreset_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
